// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional counters are enabled with the IFETCH_PERF_EN macro (see ifetch_unit).
package ifetch_pkg;
    localparam int INSTR_W      = 32;
    localparam int PC_STEP      = 4;
    localparam int FETCH_ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0]      instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_if.sv
// ROM read port plus decode-side valid/ready handshake of the fetch unit.
// master = fetch unit, slave = ROM/decode environment.
interface ifetch_if import ifetch_pkg::*; #(
    parameter int ADDR_W = FETCH_ADDR_W
) ();
    logic [ADDR_W-1:0]  address;
    logic               en;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output address, en, instr, instr_pc, instr_valid,
        input  rom_data, instr_ready
    );

    modport slave (
        input  address, en, instr, instr_pc, instr_valid,
        output rom_data, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} entries.
// Pointers carry one extra wrap bit; i_clear empties it in one edge and overrides push/pop.
module fetch_fifo import ifetch_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int W     = $bits(fetch_entry_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                       (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO can still accept a write when the head leaves on the same edge.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[IDX_W-1:0]] <= i_wdata;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_head  = r_mem[r_rd_ptr[IDX_W-1:0]];
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC, run/fault FSM, ROM port and fetch FIFO to decode.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_stall counters.
//
// state | meaning
// IDLE  | not fetching; decode may still drain the FIFO
// RUN   | fetching one word per cycle while run=1 and the FIFO has room
// FAULT | misaligned redirect seen; waits for an aligned redirect
module ifetch_unit import ifetch_pkg::*; #(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    ifetch_if.master          bus,
    output logic              o_fault
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       o_perf_fetched,
    output logic [31:0]       o_perf_stall
`endif
);
    localparam int EW = INSTR_W + ADDR_W;

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic              w_en;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_aligned;
    logic [EW-1:0]     w_head;

    assign w_pop     = !w_empty && bus.instr_ready;
    assign w_aligned = (i_redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_en         = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_run) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (!i_run) begin
                    w_next_state = IDLE;
                end else begin
                    w_en = !w_full || w_pop;
                end
            end
            FAULT: begin
                w_next_state = FAULT;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        // Redirect outranks every state transition; the same-cycle read is dropped by the flush.
        if (i_redirect) begin
            if (w_aligned) begin
                w_next_state = i_run ? RUN : IDLE;
            end else begin
                w_next_state = FAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            if (w_aligned) begin
                r_pc <= i_redirect_pc;
            end
        end else if (w_en) begin
            r_pc <= r_pc + ADDR_W'(PC_STEP);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (i_redirect),
        .i_push  (w_en),
        .i_pop   (w_pop),
        .i_wdata ({bus.rom_data, r_pc}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign bus.address     = r_pc;
    assign bus.en          = w_en;
    assign bus.instr       = w_head[EW-1 -: INSTR_W];
    assign bus.instr_pc    = w_head[ADDR_W-1:0];
    assign bus.instr_valid = !w_empty;
    assign o_fault         = (r_state == FAULT);

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_en && !i_redirect) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if ((r_state == RUN) && !w_en) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_stall   = r_perf_stall;
`endif
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front end; drives the instruction ROM read port (7-bit byte address, enable, 32-bit combinational data).
- Owns the PC, captures ROM words into a small FIFO and presents {instr, pc} to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute; flags misaligned targets.

Parameters:
ADDR_W, 7, byte-address width of the ROM; the PC wraps modulo 2^ADDR_W.
DEPTH, 2, fetch FIFO entries (power of two, at least 2).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
run  in  1  level; fetching is permitted while high
redirect  in  1  one-cycle pulse from execute: flush and refetch
redirect_pc  in  ADDR_W  redirect target byte address
address  out  ADDR_W  ROM read address (= pc)
en  out  1  ROM read enable
rom_data  in  32  ROM output, valid in the same cycle as address/en
instr  out  32  FIFO head instruction
instr_pc  out  ADDR_W  byte address of instr
instr_valid  out  1  FIFO non-empty
instr_ready  in  1  decode accepts head this cycle
fault  out  1  misaligned redirect latched

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, FIFO empty, state=IDLE. After reset: instr_valid=0, fault=0, en=0, instr=0, instr_pc=0, address=RESET_PC. rst overrides all other inputs, including mid-fetch and mid-handshake.
- FSM states:
  - IDLE: en=0. Moves to RUN when run=1.
  - RUN: fetches while run=1. Moves to IDLE when run=0; pc and FIFO are held and decode may keep draining.
  - FAULT: en=0, fault=1. Leaves only on an aligned redirect (to RUN if run=1, else IDLE) or on rst.
- Fetch in RUN:
  - en=1 when the FIFO is not full, or is full with pop = instr_valid & instr_ready in the same cycle.
  - When en=1: at the edge, push {rom_data, pc} and set pc <= pc+4 mod 2^ADDR_W (124 -> 0 when ADDR_W=7).
  - When en=0: pc holds; address still shows pc.
- Latency: an instruction fetched in cycle N is visible on instr/instr_valid in cycle N+1. Steady-state throughput is 1 instr/cycle while instr_ready=1.
- Handshake:
  - Pop occurs when instr_valid & instr_ready. Head advances at the edge.
  - instr/instr_pc stay stable while valid and not ready.
  - instr, instr_pc and instr_valid are combinational from FIFO registers only, never from rom_data.
- Simultaneous push and pop: allowed in every state; occupancy is unchanged.
- Redirect (highest priority after rst, evaluated in any state):
  - Aligned (redirect_pc[1:0]==0): at the edge, flush FIFO (any same-cycle push/pop is discarded), pc <= redirect_pc, fault cleared, state to RUN if run=1 else IDLE.
  - Misaligned: flush, pc unchanged, state=FAULT, fault=1 from the next cycle.
  - Timing: instr_valid=0 in cycle N+1; the first target instruction is valid in cycle N+2.
  - en may be 1 in the redirect cycle; that read is discarded.
- FIFO pointers are (log2 DEPTH)+1 bits. Full when MSBs differ and index bits match; empty when the pointers are equal.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched (32-bit, +1 per push) and perf_stall (32-bit, +1 per cycle in RUN with en=0).
  - Both reset to 0 on rst and wrap at 2^32; redirect does not clear them.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package ifetch_pkg:
  - INSTR_W=32 and the state enum {IDLE, RUN, FAULT}.
  - Constant PC_STEP=4.
  - Typedef fetch_entry_t {instr[31:0], pc[ADDR_W-1:0]}.
- Sub-module fetch_fifo:
  - Parameterised DEPTH/width, synchronous clear input driven by redirect.
  - Ports push, pop, full, empty, head.
  - The top keeps the PC, FSM and ROM interface.

Test Plan:
1. Reset then run=1, instr_ready=1; ROM words at 0,4,8 = 0x00000000, 0x00348093, 0x00138193 -> address 0,4,8,... on consecutive cycles; instr_valid from cycle 2; instr_pc 0,4,8 with matching words, one per cycle.
2. instr_ready=0 for 5 cycles -> FIFO fills to 2 entries; en=0 and pc frozen at 8; head stays {0x00000000, 0}. Release ready -> entries drain in order with no drop or duplicate.
3. redirect=1, redirect_pc=0x04 while FIFO is full -> next cycle instr_valid=0, address=4; cycle after, instr_pc=4 with instr=0x00348093; no stale entries appear.
4. redirect_pc=0x06 -> fault=1, en=0 and instr_valid=0 next cycle. Then redirect_pc=0x10 -> fault=0 and fetching resumes at 0x10.
5. redirect_pc=0x7C with ADDR_W=7 -> instr_pc sequence 0x7C then 0x00 (wrap).
6. rst pulsed mid-stream with FIFO holding 1 entry and simultaneous redirect -> reset wins: pc=0, instr_valid=0, fault=0; with IFETCH_PERF_EN defined, perf_fetched=0 and perf_stall=0.
